seg_monitor: RTL and testbench

SEG_MONITOR -- requirements
Module: seg_monitor

---
 rtl/seg_monitor_pkg.sv | 62 ++++++
 rtl/seg_fifo.sv | 62 ++++++
 rtl/seg_monitor.sv | 134 +++++++++++++
 tb/tb_seg_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_monitor_pkg.sv
// Shared definitions for the seven-segment display monitor: segment codes,
// FSM state encoding, decoded-digit record and the segment decode function.
package seg_monitor_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Stability FSM: TRACK waits for a steady pair, HOLD waits for it to change.
  typedef logic [0:0] state_t;
  localparam state_t ST_TRACK = 1'b0;
  localparam state_t ST_HOLD  = 1'b1;

  // One decoded digit: hex value plus a flag telling whether the pattern was legal.
  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } seg_dec_t;

  // Map a segment pattern to its hex digit; anything not in the table is invalid.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t dec;
    dec.valid = 1'b1;
    dec.value = 4'h0;
    case (seg)
      SEG_0:   dec.value = 4'h0;
      SEG_1:   dec.value = 4'h1;
      SEG_2:   dec.value = 4'h2;
      SEG_3:   dec.value = 4'h3;
      SEG_4:   dec.value = 4'h4;
      SEG_5:   dec.value = 4'h5;
      SEG_6:   dec.value = 4'h6;
      SEG_7:   dec.value = 4'h7;
      SEG_8:   dec.value = 4'h8;
      SEG_9:   dec.value = 4'h9;
      SEG_A:   dec.value = 4'hA;
      SEG_B:   dec.value = 4'hB;
      SEG_C:   dec.value = 4'hC;
      SEG_D:   dec.value = 4'hD;
      SEG_E:   dec.value = 4'hE;
      SEG_F:   dec.value = 4'hF;
      default: dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// First-word-fall-through FIFO. Pointers carry one extra bit so that full and
// empty are distinguishable; a push while full is accepted only if a pop
// frees the head slot on the same edge. rdata reads zero while empty.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted operations, next pointers and head read-out.
  // NOTE: every output of a combinational block gets a value on every path
  // (here by direct assignment, elsewhere by defaults at the top) so no latch is inferred.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers with synchronous active-low clear.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; the pointers alone decide which
  // entries are live, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/seg_monitor.sv
// Seven-segment display monitor: samples a two-digit display, waits until the
// pair has been steady for STABLE_CYCLES cycles, decodes it and queues each new
// distinct value. Illegal steady patterns raise a sticky err; commits lost to a
// full queue raise a sticky overflow.
module seg_monitor
  import seg_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] num1,
  input  logic [6:0] num2,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic       overflow
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  logic [13:0] s_q, s_d;
  logic [3:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [13:0] last_pair_q, last_pair_d;
  logic        last_valid_q, last_valid_d;
  logic        err_q, err_d;
  logic        overflow_q, overflow_d;

  logic [13:0] in_pair;
  logic        same;
  logic        commit;
  logic        pair_ok;
  logic        is_dup;
  logic        push;
  logic        pop;
  seg_dec_t    dec_hi;
  seg_dec_t    dec_lo;
  logic [7:0]  push_data;
  logic        fifo_full;
  logic        fifo_empty;

  // Sampler, stability counter, FSM and commit/decode decisions.
  always_comb begin
    in_pair      = {num1, num2};
    same         = (in_pair == s_q);
    s_d          = in_pair;
    state_d      = state_q;
    commit       = 1'b0;
    last_pair_d  = last_pair_q;
    last_valid_d = last_valid_q;

    if (!same) begin
      cnt_d = 4'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      ST_TRACK: begin
        if (cnt_q == CNT_MAX) begin
          commit = 1'b1;
          // A change arriving on the commit edge must not be swallowed by HOLD,
          // so stay in TRACK and start counting the new pair immediately.
          state_d = same ? ST_HOLD : ST_TRACK;
        end
      end
      ST_HOLD: begin
        if (!same) state_d = ST_TRACK;
      end
      default: state_d = ST_TRACK;
    endcase

    dec_hi    = seg_decode(s_q[13:7]);
    dec_lo    = seg_decode(s_q[6:0]);
    pair_ok   = dec_hi.valid && dec_lo.valid;
    is_dup    = last_valid_q && (s_q == last_pair_q);
    push      = commit && pair_ok && !is_dup;
    push_data = {dec_hi.value, dec_lo.value};

    if (push) begin
      last_pair_d  = s_q;
      last_valid_d = 1'b1;
    end

    pop        = out_valid && out_ready;
    err_d      = err_q | (commit && !pair_ok);
    overflow_d = overflow_q | (push && fifo_full && !pop);
  end

  // State registers; clr=0 returns everything to the idle TRACK state.
  always_ff @(posedge clk) begin
    if (!clr) begin
      s_q          <= {SEG_BLANK, SEG_BLANK};
      cnt_q        <= 4'd0;
      state_q      <= ST_TRACK;
      last_pair_q  <= {SEG_BLANK, SEG_BLANK};
      last_valid_q <= 1'b0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      last_pair_q  <= last_pair_d;
      last_valid_q <= last_valid_d;
      err_q        <= err_d;
      overflow_q   <= overflow_d;
    end
  end

  seg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign err       = err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg_monitor.sv
// Directed bench for seg_monitor with STABLE_CYCLES=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_monitor;

  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C1 = 7'b1001111;
  localparam logic [6:0] C2 = 7'b0010010;
  localparam logic [6:0] C3 = 7'b0000110;
  localparam logic [6:0] C4 = 7'b1001100;
  localparam logic [6:0] C5 = 7'b0100100;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] CB = 7'b1111111;

  logic       clk = 1'b0;
  logic       clr;
  logic [6:0] num1;
  logic [6:0] num2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       overflow;

  logic [6:0] lo_code [1:5];
  int         total = 0;
  int         bad   = 0;

  seg_monitor #(
    .STABLE_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .num1      (num1),
    .num2      (num2),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    clr = 1'b0;
    step(2);
    clr = 1'b1;
  endtask

  initial begin
    lo_code[1] = C1;
    lo_code[2] = C2;
    lo_code[3] = C3;
    lo_code[4] = C4;
    lo_code[5] = C5;

    clr       = 1'b0;
    num1      = CB;
    num2      = CB;
    out_ready = 1'b0;
    step(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_err", err, 0);
    check("rst_ovf", overflow, 0);

    // Basic capture and latency of pair 3/8.
    clr  = 1'b1;
    num1 = C3;
    num2 = C8;
    step(4);
    check("lat_early_valid", out_valid, 0);
    step(1);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h38);
    check("lat_err", err, 0);

    // Long hold, then a short glitch: still only the one entry.
    step(50);
    check("hold_data", out_data, 8'h38);
    num1 = CB;
    num2 = CB;
    step(3);
    num1 = C3;
    num2 = C8;
    step(20);
    check("glitch_err", err, 0);
    check("glitch_valid", out_valid, 1);
    check("glitch_data", out_data, 8'h38);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("glitch_one_entry", out_valid, 0);
    check("glitch_empty_data", out_data, 8'h00);

    // Illegal high digit: err after the stability window, sticky.
    num1 = CB;
    num2 = C0;
    step(4);
    check("err_early", err, 0);
    step(1);
    check("err_set", err, 1);
    check("err_no_push", out_valid, 0);
    step(10);
    check("err_sticky", err, 1);

    // Overflow: five distinct pairs with the consumer stalled.
    apply_reset();
    check("rst2_err", err, 0);
    for (int i = 1; i <= 5; i++) begin
      num1 = C0;
      num2 = lo_code[i];
      step(10);
      if (i == 4) check("ovf_before", overflow, 0);
    end
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_valid", out_valid, 1);
      check("ovf_pop_data", out_data, 32'(i));
      step(1);
    end
    check("ovf_drained_valid", out_valid, 0);
    check("ovf_drained_data", out_data, 8'h00);
    out_ready = 1'b0;

    // Full FIFO, commit coinciding with a pop.
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      num1 = C0;
      num2 = lo_code[i];
      step(10);
    end
    num2 = C5;
    step(4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("fullpp_ovf", overflow, 0);
    check("fullpp_head", out_data, 8'h02);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("fullpp_pop_data", out_data, 32'(i));
      step(1);
    end
    check("fullpp_empty", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-operation with entries queued and a count running.
    apply_reset();
    num1 = CB;
    num2 = CB;
    step(6);
    check("midrst_err_pre", err, 1);
    for (int i = 1; i <= 2; i++) begin
      num1 = C0;
      num2 = lo_code[i];
      step(10);
    end
    check("midrst_head_pre", out_data, 8'h01);
    num2 = C3;
    step(2);
    clr = 1'b0;
    step(1);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_err", err, 0);
    check("midrst_ovf", overflow, 0);
    clr = 1'b1;
    step(4);
    check("midrst_early", out_valid, 0);
    step(1);
    check("midrst_repush_valid", out_valid, 1);
    check("midrst_repush_data", out_data, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
